regfile_wb_arbiter: RTL and testbench

//   Owns the single write port (regwrite/wr/wd) of the 32x32 register file.

---
 rtl/regfile_wb_arbiter_if.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 94 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back request and register-file write-port bundle
interface regfile_wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              regwrite;
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wd;
    logic              init_done;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        output alu_ready, ld_ready,
        output regwrite, wr, wd, init_done
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        input  alu_ready, ld_ready,
        input  regwrite, wr, wd, init_done
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port owner: zero-fill after reset, then round-robin ALU/load write-back
module regfile_wb_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int CLEAR_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   wb
);
    typedef enum logic [1:0] {
        S_CLEAR,
        S_LAST,
        S_RUN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              rr_ld;
    logic              regwrite_q;
    logic [ADDR_W-1:0] wr_q;
    logic [DATA_W-1:0] wd_q;
    logic              init_done_q;
    logic              run;
    logic              grant_alu;
    logic              grant_ld;

    // rr_ld=0 gives the ALU priority on a tie, rr_ld=1 gives it to the load path
    always_comb begin
        run       = (state == S_RUN);
        grant_alu = run && wb.alu_valid && (!wb.ld_valid || !rr_ld);
        grant_ld  = run && wb.ld_valid && (!wb.alu_valid || rr_ld);
    end

    assign wb.alu_ready = grant_alu;
    assign wb.ld_ready  = grant_ld;
    assign wb.regwrite  = regwrite_q;
    assign wb.wr        = wr_q;
    assign wb.wd        = wd_q;
    assign wb.init_done = init_done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= (CLEAR_EN != 0) ? S_CLEAR : S_RUN;
            clr_cnt     <= '0;
            rr_ld       <= 1'b0;
            regwrite_q  <= 1'b0;
            wr_q        <= '0;
            wd_q        <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    regwrite_q <= 1'b1;
                    wr_q       <= clr_cnt;
                    wd_q       <= '0;
                    clr_cnt    <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_IDX) begin
                        state <= S_LAST;
                    end
                end
                // Last clear write is on the port this cycle; arbitration opens next cycle
                S_LAST: begin
                    regwrite_q  <= 1'b0;
                    init_done_q <= 1'b1;
                    state       <= S_RUN;
                end
                S_RUN: begin
                    init_done_q <= 1'b1;
                    if (grant_alu) begin
                        regwrite_q <= (wb.alu_rd != '0);
                        wr_q       <= wb.alu_rd;
                        wd_q       <= wb.alu_data;
                        rr_ld      <= 1'b1;
                    end else if (grant_ld) begin
                        regwrite_q <= (wb.ld_rd != '0);
                        wr_q       <= wb.ld_rd;
                        wd_q       <= wb.ld_data;
                        rr_ld      <= 1'b0;
                    end else begin
                        regwrite_q <= 1'b0;
                    end
                end
                default: begin
                    regwrite_q <= 1'b0;
                    state      <= S_RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) wb ();

    regfile_wb_arbiter #(
        .ADDR_W(5), .DATA_W(32), .NREGS(32), .CLEAR_EN(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb (wb.slave)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldd;
        logic        exp_ar;
        logic        exp_lr;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  last_wr;
    logic [31:0] last_wd;
    vec_t        tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drain();
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("regwrite", {31'd0, wb.regwrite}, {31'd0, e.rw});
            chk("wr", {27'd0, wb.wr}, {27'd0, e.wr});
            chk("wd", wb.wd, e.wd);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        drain();
        wb.alu_valid = v.av;
        wb.alu_rd    = v.ard;
        wb.alu_data  = v.ad;
        wb.ld_valid  = v.lv;
        wb.ld_rd     = v.lrd;
        wb.ld_data   = v.ldd;
        #1;
        chk("alu_ready", {31'd0, wb.alu_ready}, {31'd0, v.exp_ar});
        chk("ld_ready", {31'd0, wb.ld_ready}, {31'd0, v.exp_lr});
        chk("init_done_run", {31'd0, wb.init_done}, 32'd1);
        if (v.exp_ar) begin
            last_wr = v.ard;
            last_wd = v.ad;
            e.rw    = (v.ard != 5'd0);
        end else if (v.exp_lr) begin
            last_wr = v.lrd;
            last_wd = v.ldd;
            e.rw    = (v.lrd != 5'd0);
        end else begin
            e.rw    = 1'b0;
        end
        e.wr = last_wr;
        e.wd = last_wd;
        sb.push_back(e);
    endtask

    initial begin
        //           av    ard    ad            lv    lrd    ldd          ar    lr
        tbl[0]  = '{1'b1, 5'd5,  32'h1234,     1'b0, 5'd0,  32'h0,      1'b1, 1'b0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFF,   1'b0, 1'b1};
        tbl[2]  = '{1'b1, 5'd3,  32'hA,        1'b1, 5'd7,  32'hB,      1'b1, 1'b0};
        tbl[3]  = '{1'b1, 5'd3,  32'hA,        1'b1, 5'd7,  32'hB,      1'b0, 1'b1};
        tbl[4]  = '{1'b1, 5'd3,  32'hA,        1'b1, 5'd7,  32'hB,      1'b1, 1'b0};
        tbl[5]  = '{1'b1, 5'd3,  32'hA,        1'b1, 5'd7,  32'hB,      1'b0, 1'b1};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b0, 1'b0};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'hCAFE,   1'b0, 1'b1};
        tbl[8]  = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd2,  32'h22,     1'b1, 1'b0};
        tbl[9]  = '{1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0,      1'b1, 1'b0};
        tbl[10] = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd6,  32'h66,     1'b0, 1'b1};
        tbl[11] = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd8,  32'h88,     1'b1, 1'b0};
        tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  32'h88,     1'b0, 1'b1};
        tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b0, 1'b0};

        // ALU request held through reset and CLEAR; it must wait for RUN
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd5;
        wb.alu_data  = 32'h1234;
        wb.ld_valid  = 1'b0;
        wb.ld_rd     = 5'd0;
        wb.ld_data   = 32'h0;
        rst          = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_regwrite", {31'd0, wb.regwrite}, 32'd0);
        chk("rst_wr", {27'd0, wb.wr}, 32'd0);
        chk("rst_wd", wb.wd, 32'd0);
        chk("rst_init_done", {31'd0, wb.init_done}, 32'd0);
        chk("rst_alu_ready", {31'd0, wb.alu_ready}, 32'd0);
        chk("rst_ld_ready", {31'd0, wb.ld_ready}, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("clr_regwrite", {31'd0, wb.regwrite}, 32'd1);
            chk("clr_wr", {27'd0, wb.wr}, k);
            chk("clr_wd", wb.wd, 32'd0);
            chk("clr_init_done", {31'd0, wb.init_done}, 32'd0);
            chk("clr_alu_ready", {31'd0, wb.alu_ready}, 32'd0);
        end
        last_wr = 5'd31;
        last_wd = 32'd0;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i]);
        end
        @(negedge clk);
        drain();

        // Async reset while a registered write is on the port
        @(negedge clk);
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd12;
        wb.alu_data  = 32'h5A5A;
        #1;
        chk("run_alu_ready", {31'd0, wb.alu_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("pre_abort_regwrite", {31'd0, wb.regwrite}, 32'd1);
        chk("pre_abort_wr", {27'd0, wb.wr}, 32'd12);
        rst = 1'b0;
        #1;
        chk("abort_regwrite", {31'd0, wb.regwrite}, 32'd0);
        chk("abort_wr", {27'd0, wb.wr}, 32'd0);
        chk("abort_wd", wb.wd, 32'd0);
        chk("abort_init_done", {31'd0, wb.init_done}, 32'd0);
        chk("abort_alu_ready", {31'd0, wb.alu_ready}, 32'd0);
        wb.alu_valid = 1'b0;

        // Reset during CLEAR at count 10, then CLEAR restarts from index 0
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("clr2_wr", {27'd0, wb.wr}, k);
        end
        #2;
        rst = 1'b0;
        #1;
        chk("clr_abort_regwrite", {31'd0, wb.regwrite}, 32'd0);
        chk("clr_abort_wr", {27'd0, wb.wr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("restart_regwrite", {31'd0, wb.regwrite}, 32'd1);
        chk("restart_wr0", {27'd0, wb.wr}, 32'd0);
        @(negedge clk);
        chk("restart_wr1", {27'd0, wb.wr}, 32'd1);
        chk("restart_init_done", {31'd0, wb.init_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
